// File: rtl/count_match_monitor_if.sv
// Bus bundle between the count source / host and count_match_monitor:
// sample and control inputs plus the result and statistics outputs.
interface count_match_monitor_if #(
   parameter int CW = 4,
   parameter int TW = 16
) ();
   logic          start;
   logic          clr;
   logic          cnt_vld;
   logic [CW-1:0] cnt;
   logic [CW-1:0] exp_val;
   logic          hit;
   logic          miss;
   logic [7:0]    hit_cnt;
   logic [7:0]    miss_cnt;
   logic [TW-1:0] first_miss_time;
   logic [CW-1:0] first_miss_val;
   logic          miss_seen;
   logic          fault;
   logic [1:0]    state;

   modport master (
      output start, clr, cnt_vld, cnt, exp_val,
      input  hit, miss, hit_cnt, miss_cnt, first_miss_time, first_miss_val,
             miss_seen, fault, state
   );

   modport slave (
      input  start, clr, cnt_vld, cnt, exp_val,
      output hit, miss, hit_cnt, miss_cnt, first_miss_time, first_miss_val,
             miss_seen, fault, state
   );
endinterface

// File: rtl/count_match_monitor.sv
// Checker for a free-running counter: after an arm/skip phase, compares each
// valid sample against a run-time expected value, keeps saturating hit/miss
// statistics, timestamps the first miss and latches a sticky fault once the
// miss count reaches ERR_LIMIT.
module count_match_monitor #(
   parameter int CW        = 4,
   parameter int TW        = 16,
   parameter int SKIP      = 2,
   parameter int ERR_LIMIT = 3
) (
   input logic                  clk,
   input logic                  RST,
   count_match_monitor_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      CHECK = 2'd2,
      FAULT = 2'd3
   } state_e;

   localparam int              SW       = (SKIP > 1) ? $clog2(SKIP + 1) : 1;
   localparam logic [SW-1:0]   SKIP_LD  = SW'(SKIP);
   localparam logic [7:0]      CNT_MAX  = 8'hFF;
   localparam logic [7:0]      LIMIT    = 8'(ERR_LIMIT);

   state_e         state_q, state_d;
   logic [SW-1:0]  skip_q, skip_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic           hit_q, hit_d;
   logic           miss_q, miss_d;
   logic [7:0]     hit_cnt_q, hit_cnt_d;
   logic [7:0]     miss_cnt_q, miss_cnt_d;
   logic [TW-1:0]  first_miss_time_q, first_miss_time_d;
   logic [CW-1:0]  first_miss_val_q, first_miss_val_d;
   logic           miss_seen_q, miss_seen_d;
   logic           fault_q, fault_d;
   logic [7:0]     hit_cnt_inc, miss_cnt_inc;

   // Next-state and next-statistics logic; clr overrides everything else.
   always_comb begin
      // NOTE: every _d signal gets a default before any branch, so no path
      // leaves one unassigned and no latch is inferred.
      state_d           = state_q;
      skip_d            = skip_q;
      timer_d           = timer_q + TW'(1);
      hit_d             = 1'b0;
      miss_d            = 1'b0;
      hit_cnt_d         = hit_cnt_q;
      miss_cnt_d        = miss_cnt_q;
      first_miss_time_d = first_miss_time_q;
      first_miss_val_d  = first_miss_val_q;
      miss_seen_d       = miss_seen_q;
      fault_d           = fault_q;
      hit_cnt_inc       = (hit_cnt_q  == CNT_MAX) ? hit_cnt_q  : hit_cnt_q  + 8'd1;
      miss_cnt_inc      = (miss_cnt_q == CNT_MAX) ? miss_cnt_q : miss_cnt_q + 8'd1;

      if (bus.clr) begin
         // The timer keeps running; only the monitor's own state is cleared.
         state_d           = IDLE;
         skip_d            = '0;
         hit_cnt_d         = '0;
         miss_cnt_d        = '0;
         first_miss_time_d = '0;
         first_miss_val_d  = '0;
         miss_seen_d       = 1'b0;
         fault_d           = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  if (SKIP == 0) begin
                     state_d = CHECK;
                  end else begin
                     state_d = ARMED;
                     skip_d  = SKIP_LD;
                  end
               end
            end
            ARMED: begin
               // The sample that empties the skip counter is itself discarded.
               if (bus.cnt_vld) begin
                  skip_d = skip_q - SW'(1);
                  if (skip_q == SW'(1)) state_d = CHECK;
               end
            end
            CHECK: begin
               if (bus.cnt_vld) begin
                  if (bus.cnt == bus.exp_val) begin
                     hit_d     = 1'b1;
                     hit_cnt_d = hit_cnt_inc;
                  end else begin
                     miss_d     = 1'b1;
                     miss_cnt_d = miss_cnt_inc;
                     if (!miss_seen_q) begin
                        first_miss_time_d = timer_q;
                        first_miss_val_d  = bus.cnt;
                        miss_seen_d       = 1'b1;
                     end
                     if (miss_cnt_inc == LIMIT) begin
                        fault_d = 1'b1;
                        state_d = FAULT;
                     end
                  end
               end
            end
            FAULT:   ; // frozen until clr or reset
            default: state_d = IDLE;
         endcase
      end
   end

   // State, timer and statistics registers with asynchronous reset.
   always_ff @(posedge clk or negedge RST) begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge value of every other register, independent of statement order.
      if (!RST) begin
         state_q           <= IDLE;
         skip_q            <= '0;
         timer_q           <= '0;
         hit_q             <= 1'b0;
         miss_q            <= 1'b0;
         hit_cnt_q         <= '0;
         miss_cnt_q        <= '0;
         first_miss_time_q <= '0;
         first_miss_val_q  <= '0;
         miss_seen_q       <= 1'b0;
         fault_q           <= 1'b0;
      end else begin
         state_q           <= state_d;
         skip_q            <= skip_d;
         timer_q           <= timer_d;
         hit_q             <= hit_d;
         miss_q            <= miss_d;
         hit_cnt_q         <= hit_cnt_d;
         miss_cnt_q        <= miss_cnt_d;
         first_miss_time_q <= first_miss_time_d;
         first_miss_val_q  <= first_miss_val_d;
         miss_seen_q       <= miss_seen_d;
         fault_q           <= fault_d;
      end
   end

   assign bus.hit             = hit_q;
   assign bus.miss            = miss_q;
   assign bus.hit_cnt         = hit_cnt_q;
   assign bus.miss_cnt        = miss_cnt_q;
   assign bus.first_miss_time = first_miss_time_q;
   assign bus.first_miss_val  = first_miss_val_q;
   assign bus.miss_seen       = miss_seen_q;
   assign bus.fault           = fault_q;
   assign bus.state           = state_q;

endmodule

// File: tb/tb_count_match_monitor.sv
// Bench for count_match_monitor: three instances (SKIP/ERR_LIMIT = 2/3, 0/255,
// 2/255) share one stimulus stream. A reference model pushes each instance's
// expected outputs into a queue when the cycle's inputs are driven; they are
// popped and compared just after the clock edge. Directed checks cover the
// specific values called out for each scenario.
module tb_count_match_monitor;

   typedef struct packed {
      logic [1:0]  state;
      logic [7:0]  skip;
      logic        hit;
      logic        miss;
      logic [7:0]  hit_cnt;
      logic [7:0]  miss_cnt;
      logic [15:0] fmt;
      logic [3:0]  fmv;
      logic        seen;
      logic        fault;
   } m_t;

   localparam int SK [3] = '{2, 0, 2};
   localparam int LM [3] = '{3, 255, 255};

   logic        clk = 1'b0;
   logic        RST, start, clr, cnt_vld;
   logic [3:0]  cnt, exp_val;

   int          n_vec  = 0;
   int          n_miss = 0;
   logic [15:0] tmr    = '0;
   m_t          mdl [3];
   m_t          obs [3];
   m_t          sb_q [3][$];

   always #5 clk = ~clk;

   count_match_monitor_if if_a ();
   count_match_monitor_if if_b ();
   count_match_monitor_if if_c ();

   assign if_a.start = start;  assign if_a.clr = clr;  assign if_a.cnt_vld = cnt_vld;
   assign if_a.cnt   = cnt;    assign if_a.exp_val = exp_val;
   assign if_b.start = start;  assign if_b.clr = clr;  assign if_b.cnt_vld = cnt_vld;
   assign if_b.cnt   = cnt;    assign if_b.exp_val = exp_val;
   assign if_c.start = start;  assign if_c.clr = clr;  assign if_c.cnt_vld = cnt_vld;
   assign if_c.cnt   = cnt;    assign if_c.exp_val = exp_val;

   count_match_monitor #(.CW(4), .TW(16), .SKIP(2), .ERR_LIMIT(3))
      dut_a (.clk(clk), .RST(RST), .bus(if_a.slave));
   count_match_monitor #(.CW(4), .TW(16), .SKIP(0), .ERR_LIMIT(255))
      dut_b (.clk(clk), .RST(RST), .bus(if_b.slave));
   count_match_monitor #(.CW(4), .TW(16), .SKIP(2), .ERR_LIMIT(255))
      dut_c (.clk(clk), .RST(RST), .bus(if_c.slave));

   assign obs[0] = '{state: if_a.state, skip: 8'd0, hit: if_a.hit, miss: if_a.miss,
                     hit_cnt: if_a.hit_cnt, miss_cnt: if_a.miss_cnt, fmt: if_a.first_miss_time,
                     fmv: if_a.first_miss_val, seen: if_a.miss_seen, fault: if_a.fault};
   assign obs[1] = '{state: if_b.state, skip: 8'd0, hit: if_b.hit, miss: if_b.miss,
                     hit_cnt: if_b.hit_cnt, miss_cnt: if_b.miss_cnt, fmt: if_b.first_miss_time,
                     fmv: if_b.first_miss_val, seen: if_b.miss_seen, fault: if_b.fault};
   assign obs[2] = '{state: if_c.state, skip: 8'd0, hit: if_c.hit, miss: if_c.miss,
                     hit_cnt: if_c.hit_cnt, miss_cnt: if_c.miss_cnt, fmt: if_c.first_miss_time,
                     fmv: if_c.first_miss_val, seen: if_c.miss_seen, fault: if_c.fault};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   // Reference model: one clock of behaviour for given parameters and inputs.
   function automatic m_t step(input m_t m, input int skip_p, input int lim,
                               input logic st, input logic cl, input logic vld,
                               input logic [3:0] c, input logic [3:0] e,
                               input logic [15:0] t);
      m_t n = m;
      n.hit  = 1'b0;
      n.miss = 1'b0;
      if (cl) return '0;
      unique case (m.state)
         2'd0: if (st) begin
                  n.state = (skip_p == 0) ? 2'd2 : 2'd1;
                  n.skip  = 8'(skip_p);
               end
         2'd1: if (vld) begin
                  n.skip = m.skip - 8'd1;
                  if (n.skip == 8'd0) n.state = 2'd2;
               end
         2'd2: if (vld) begin
                  if (c == e) begin
                     n.hit = 1'b1;
                     if (m.hit_cnt != 8'd255) n.hit_cnt = m.hit_cnt + 8'd1;
                  end else begin
                     n.miss = 1'b1;
                     if (m.miss_cnt != 8'd255) n.miss_cnt = m.miss_cnt + 8'd1;
                     if (!m.seen) begin
                        n.fmt  = t;
                        n.fmv  = c;
                        n.seen = 1'b1;
                     end
                     if (n.miss_cnt == 8'(lim)) begin
                        n.fault = 1'b1;
                        n.state = 2'd3;
                     end
                  end
               end
         default: ;
      endcase
      return n;
   endfunction

   task automatic cmp_all(input int i, input m_t got, input m_t want);
      string p;
      p = $sformatf("inst%0d", i);
      check({p, ".state"},     32'(got.state),    32'(want.state));
      check({p, ".hit"},       32'(got.hit),      32'(want.hit));
      check({p, ".miss"},      32'(got.miss),     32'(want.miss));
      check({p, ".hit_cnt"},   32'(got.hit_cnt),  32'(want.hit_cnt));
      check({p, ".miss_cnt"},  32'(got.miss_cnt), 32'(want.miss_cnt));
      check({p, ".fm_time"},   32'(got.fmt),      32'(want.fmt));
      check({p, ".fm_val"},    32'(got.fmv),      32'(want.fmv));
      check({p, ".miss_seen"}, 32'(got.seen),     32'(want.seen));
      check({p, ".fault"},     32'(got.fault),    32'(want.fault));
      check({p, ".excl"},      32'(got.hit & got.miss), 32'd0);
   endtask

   // Drive one cycle at the falling edge, queue the model's prediction,
   // then compare just after the rising edge.
   task automatic cycle(input logic r, input logic st, input logic cl,
                        input logic vld, input logic [3:0] c, input logic [3:0] e);
      m_t want;
      @(negedge clk);
      RST = r; start = st; clr = cl; cnt_vld = vld; cnt = c; exp_val = e;
      for (int i = 0; i < 3; i++) begin
         mdl[i] = r ? step(mdl[i], SK[i], LM[i], st, cl, vld, c, e, tmr) : '0;
         sb_q[i].push_back(mdl[i]);
      end
      tmr = r ? tmr + 16'd1 : 16'd0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         want = sb_q[i].pop_front();
         cmp_all(i, obs[i], want);
      end
   endtask

   initial begin
      RST = 1'b0; start = 1'b0; clr = 1'b0; cnt_vld = 1'b0; cnt = '0; exp_val = '0;
      for (int i = 0; i < 3; i++) mdl[i] = '0;

      // Reset state
      repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 4'd9);
      check("rst_state", 32'(if_a.state), 32'd0);
      check("rst_hcnt",  32'(if_b.hit_cnt), 32'd0);

      // Counter sweep: start in the fifth cycle, two passes of 0..15 vs 9
      repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd9);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd9);
      for (int p = 0; p < 2; p++) begin
         for (int v = 0; v < 16; v++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b1, 4'(v), 4'd9);
            if (p == 0 && v == 4) begin
               check("sweep_fault",   32'(if_a.fault),    32'd1);
               check("sweep_fstate",  32'(if_a.state),    32'd3);
               check("sweep_mcnt_a",  32'(if_a.miss_cnt), 32'd3);
            end
            if (v == 9) check("sweep_hit", 32'(if_c.hit), 32'd1);
            if (p == 0 && v == 15) begin
               check("pass1_hcnt", 32'(if_c.hit_cnt),  32'd1);
               check("pass1_mcnt", 32'(if_c.miss_cnt), 32'd13);
            end
         end
      end
      check("fault_sticky", 32'(if_a.state), 32'd3);

      // clr together with start in FAULT, then start
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 4'd9);
      check("clr_state", 32'(if_a.state),    32'd0);
      check("clr_fault", 32'(if_a.fault),    32'd0);
      check("clr_mcnt",  32'(if_a.miss_cnt), 32'd0);
      check("clr_seen",  32'(if_a.miss_seen), 32'd0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd9);
      check("restart_a", 32'(if_a.state), 32'd1);
      check("restart_b", 32'(if_b.state), 32'd2);

      // cnt_vld toggling in CHECK
      for (int k = 0; k < 10; k++) begin
         cycle(1'b1, 1'b0, 1'b0, (k % 2 == 0), 4'd9, 4'd9);
         check("toggle_hit", 32'(if_b.hit), (k % 2 == 0) ? 32'd1 : 32'd0);
      end
      check("toggle_hcnt", 32'(if_b.hit_cnt), 32'd5);

      // Hit counter saturation
      repeat (300) cycle(1'b1, 1'b0, 1'b0, 1'b1, 4'd9, 4'd9);
      check("sat_hcnt",  32'(if_b.hit_cnt),  32'd255);
      check("sat_mcnt",  32'(if_b.miss_cnt), 32'd0);
      check("sat_fault", 32'(if_b.fault),    32'd0);

      // Reset pulse with a miss in flight
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd9);
      check("rst_drop_miss", 32'(if_b.miss),  32'd0);
      check("rst_state_b",   32'(if_b.state), 32'd0);

      // First-miss capture at timer 100, later miss leaves it alone
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd9);
      while (tmr != 16'd100) cycle(1'b1, 1'b0, 1'b0, 1'b1, 4'd9, 4'd9);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 4'd9);
      check("fm_time", 32'(if_b.first_miss_time), 32'd100);
      check("fm_val",  32'(if_b.first_miss_val),  32'd3);
      check("fm_seen", 32'(if_b.miss_seen),       32'd1);
      repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b1, 4'd9, 4'd9);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 4'd9);
      check("fm_time_kept", 32'(if_b.first_miss_time), 32'd100);
      check("fm_val_kept",  32'(if_b.first_miss_val),  32'd3);
      check("fm_mcnt",      32'(if_b.miss_cnt),        32'd2);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd9);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/count_match_monitor.md
Name: count_match_monitor

Overview:
- Downstream checker stage for the 4-bit free-running counter used in the counter/assertion experiments.
- Samples the counter value each valid cycle, compares it against a run-time expected value, and keeps saturating hit/miss statistics.
- Records a cycle timestamp and the offending value for the first miss, and raises a sticky fault after a configurable number of misses.
- Synthesizable replacement for testbench-only immediate assertions: its results are checkable in RTL and visible on a waveform.

Parameters:
- CW, 4: width of sampled count and expected value.
- TW, 16: width of free-running cycle timer and timestamp.
- SKIP, 2: valid samples discarded after start before checking begins (0 = none).
- ERR_LIMIT, 3: miss count at which fault asserts (1..255).

Ports:
- clk  in  1  rising-edge clock.
- RST  in  1  asynchronous active-low reset.
- start  in  1  arm monitor (honoured in IDLE only).
- clr  in  1  synchronous clear of statistics, fault and FSM.
- cnt_vld  in  1  cnt is valid this cycle.
- cnt  in  CW  counter value under check.
- exp_val  in  CW  expected value; sampled together with cnt.
- hit  out  1  one-cycle pulse: checked sample equalled exp_val.
- miss  out  1  one-cycle pulse: checked sample differed from exp_val.
- hit_cnt  out  8  saturating hit count.
- miss_cnt  out  8  saturating miss count.
- first_miss_time  out  TW  timer value at first miss since clear.
- first_miss_val  out  CW  cnt value of first miss.
- miss_seen  out  1  first_miss_* fields are valid.
- fault  out  1  sticky; miss_cnt reached ERR_LIMIT.
- state  out  2  FSM state encoding.

Behaviour:
- Reset (RST=0, async): all outputs 0; state=IDLE; timer=0; skip counter=0.
- Timer: TW-bit register, increments every cycle while RST=1 and wraps 2^TW-1 -> 0. Cleared only by reset, not by clr.
- State encoding: IDLE=0, ARMED=1, CHECK=2, FAULT=3.
- IDLE: samples ignored. start=1 -> ARMED, loading the skip counter with SKIP; if SKIP=0, go directly to CHECK.
- ARMED: each cnt_vld decrements the skip counter. When the SKIP-th valid sample is consumed, go to CHECK; that sample itself is not checked.
- CHECK: on each cnt_vld, compare cnt with exp_val (both sampled in the same cycle). hit or miss pulses in the next cycle (latency 1). The counters update in the same cycle as the pulse.
- Saturation: hit_cnt and miss_cnt stop at 255 and do not wrap.
- First miss: on the first miss since the last clear/reset, latch first_miss_time (timer value in the sampling cycle) and first_miss_val, and set miss_seen. Later misses do not overwrite these fields.
- Fault entry: when a miss makes miss_cnt equal ERR_LIMIT, fault=1 in the same cycle as that miss pulse, and the FSM moves to FAULT.
- FAULT: no comparisons, no pulses, all statistics frozen; start is ignored. Exit only via clr or reset.
- clr=1 (any state): next cycle state=IDLE and hit_cnt, miss_cnt, first_miss_*, miss_seen, fault, hit, miss are all 0. clr takes priority over start, cnt_vld and fault entry in the same cycle.
- start while in ARMED or CHECK: ignored; the skip counter is not reloaded.
- cnt_vld=0: no compare, no pulse, state unchanged.
- hit and miss are never asserted together.
- Reset mid-CHECK: immediate return to reset values; any in-flight pulse is dropped.

Test Plan:
1. Reset, start at cycle 5, SKIP=2, cnt increments 0..15 with cnt_vld=1 every cycle, exp_val=9 -> first two samples (0,1) skipped; hit=1 exactly once per wrap, on the cycle after cnt=9; after the first pass 2..15, hit_cnt=1 and miss_cnt=13; with ERR_LIMIT=3, fault=1 after the third miss (cnt=4) and state=3 thereafter.
2. ERR_LIMIT=255, SKIP=0, exp_val=9, cnt held at 9 for 300 valid cycles -> hit_cnt saturates at 255; miss_cnt=0; fault=0.
3. Timer at 100 when the first mismatching sample cnt=3 (exp_val=9) arrives -> first_miss_time=100, first_miss_val=3, miss_seen=1; a later miss with cnt=5 leaves both fields unchanged.
4. clr and start asserted together while in FAULT -> next cycle state=0, all statistics 0, fault=0; a start one cycle later -> state=1.
5. RST pulsed low for 1 cycle mid-CHECK with a miss pulse pending -> miss stays 0; all outputs 0; timer restarts from 0.
6. cnt_vld toggling 1/0 in CHECK with cnt=9, exp_val=9 -> hit pulses only in cycles following cnt_vld=1; hit_cnt increments once per valid sample.
